multicycle_control_fsm: RTL and testbench

Sequencing controller for the team's multi-cycle RV32I variant. It shares a single ALU and a single unified instruction/data memory port across the Fetch, Decode, Execute, Memory and Writeback steps of each instruction. It sits beside the multi-cycle datapath and drives every mux select, write enable and ALU operation from a Moore state machine. A memory-ready handshake allows wait-stated memory.

---
 rtl/multicycle_control_fsm.sv | 221 ++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Moore sequencing controller for the multi-cycle RV32I datapath. One ALU and
// one unified instruction/data memory port are shared across the Fetch, Decode,
// Execute, Memory and Writeback steps. A MemReady handshake stretches FETCH,
// MEMREAD and MEMWRITE for wait-stated memory.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   Op, funct3,funct7 instruction fields from the instruction register
//   Zero              ALU zero flag (qualifies PCUpdate in BEQ)
//   MemReady          memory completes the current access this cycle
//   MemReq, MemWrite  memory request / store strobe
//   AdrSrc            memory address select (0 PC, 1 ALUOut)
//   IRWrite, PCUpdate instruction register / PC write enables
//   RegWrite          register file write enable
//   ResultSrc         00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA           00 PC, 01 OldPC, 10 rs1
//   ALUSrcB           00 rs2, 01 ImmExt, 10 constant 4
//   ImmSrc            00 I, 01 S, 10 B, 11 J
//   ALUControl        000 add, 001 sub, 010 and, 011 or, 101 slt
//   IllegalOp         one-cycle pulse in DECODE on an unsupported opcode
//   InstRet           retired-instruction count
//
// Build option: define MCFSM_INSTRET_EN to include the retired-instruction
// counter; otherwise InstRet is tied to zero and no counter flops exist.
// -----------------------------------------------------------------------------
module multicycle_control_fsm (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  Op,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic        Zero,
   input  logic        MemReady,
   output logic        MemReq,
   output logic        MemWrite,
   output logic        AdrSrc,
   output logic        IRWrite,
   output logic        PCUpdate,
   output logic        RegWrite,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ImmSrc,
   output logic [2:0]  ALUControl,
   output logic        IllegalOp,
   output logic [31:0] InstRet
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECR, EXECI, ALUWB, BEQ, JAL
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] alu_dec;
   logic       unused_funct7;

   // Only funct7[5] distinguishes sub from add.
   assign unused_funct7 = ^{funct7[6], funct7[4:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // funct7[5] selects sub only for R-type; I-type reuses those bits as imm.
   always_comb begin
      alu_dec = ALU_ADD;
      case (funct3)
         3'b000:  alu_dec = (state_q == EXECR && funct7[5]) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_dec = ALU_SLT;
         3'b110:  alu_dec = ALU_OR;
         3'b111:  alu_dec = ALU_AND;
         default: alu_dec = ALU_ADD;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      MemReq     = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      PCUpdate   = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ImmSrc     = 2'b00;
      ALUControl = ALU_ADD;
      IllegalOp  = 1'b0;

      // Immediate format follows the opcode everywhere except IDLE, which
      // keeps every output low so reset presents an all-zero control word.
      if (state_q != IDLE) begin
         case (Op)
            OP_STORE: ImmSrc = 2'b01;
            OP_BEQ:   ImmSrc = 2'b10;
            OP_JAL:   ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
         endcase
      end

      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            MemReq    = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = MemReady;
            PCUpdate  = MemReady;
            if (MemReady) state_d = DECODE;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (Op)
               OP_LOAD, OP_STORE: state_d = MEMADR;
               OP_RTYPE:          state_d = EXECR;
               OP_ITYPE:          state_d = EXECI;
               OP_BEQ:            state_d = BEQ;
               OP_JAL:            state_d = JAL;
               default: begin
                  IllegalOp = 1'b1;
                  state_d   = FETCH;
               end
            endcase
         end
         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            state_d = (Op == OP_LOAD) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            MemReq = 1'b1;
            AdrSrc = 1'b1;
            if (MemReady) state_d = MEMWB;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
            state_d   = FETCH;
         end
         MEMWRITE: begin
            MemReq   = 1'b1;
            MemWrite = 1'b1;
            AdrSrc   = 1'b1;
            if (MemReady) state_d = FETCH;
         end
         EXECR: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b00;
            ALUControl = alu_dec;
            state_d    = ALUWB;
         end
         EXECI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = alu_dec;
            state_d    = ALUWB;
         end
         ALUWB: begin
            RegWrite = 1'b1;
            state_d  = FETCH;
         end
         BEQ: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b00;
            ALUControl = ALU_SUB;
            PCUpdate   = Zero;
            state_d    = FETCH;
         end
         JAL: begin
            ALUSrcA  = 2'b01;
            ALUSrcB  = 2'b10;
            PCUpdate = 1'b1;
            state_d  = ALUWB;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef MCFSM_INSTRET_EN
   logic        retire;
   logic [31:0] instret_q, instret_d;

   // An instruction retires on the final transition back into FETCH;
   // illegal opcodes return from DECODE and are not counted.
   always_comb begin
      retire = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BEQ) ||
               (state_q == MEMWRITE && MemReady);
      instret_d = retire ? instret_q + 32'd1 : instret_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) instret_q <= '0;
      else     instret_q <= instret_d;
   end

   assign InstRet = instret_q;
`else
   assign InstRet = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  Op = '0;
   logic [2:0]  funct3 = '0;
   logic [6:0]  funct7 = '0;
   logic        Zero = 1'b0;
   logic        MemReady = 1'b0;
   logic        MemReq, MemWrite, AdrSrc, IRWrite, PCUpdate, RegWrite;
   logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0]  ALUControl;
   logic        IllegalOp;
   logic [31:0] InstRet;

   always #5 clk = ~clk;

   multicycle_control_fsm dut (
      .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
      .Zero(Zero), .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite),
      .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCUpdate(PCUpdate),
      .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
      .IllegalOp(IllegalOp), .InstRet(InstRet)
   );

   typedef struct packed {
      logic       memreq;
      logic       memwrite;
      logic       adrsrc;
      logic       irwrite;
      logic       pcupdate;
      logic       regwrite;
      logic [1:0] rsrc;
      logic [1:0] srca;
      logic [1:0] srcb;
      logic [1:0] imm;
      logic [2:0] alu;
      logic       ill;
   } ctl_t;

   typedef struct packed {
      ctl_t       c;
      logic       rdy;
      logic       zero;
      logic       retire;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
   } cyc_t;

   // instruction classes
   localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_JAL = 5, C_ILL = 6;

   cyc_t        exp_q[$];
   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   logic [31:0] model_ret = '0;
   logic [6:0]  cur_op;
   logic [2:0]  cur_f3;
   logic [6:0]  cur_f7;

   function automatic ctl_t dut_ctl();
      ctl_t a;
      a = '{MemReq, MemWrite, AdrSrc, IRWrite, PCUpdate, RegWrite, ResultSrc,
            ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalOp};
      return a;
   endfunction

   function automatic logic [31:0] exp_ret();
`ifdef MCFSM_INSTRET_EN
      return model_ret;
`else
      return 32'd0;
`endif
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [6:0] op_of(input int cls);
      case (cls)
         C_R:     return 7'b0110011;
         C_I:     return 7'b0010011;
         C_LW:    return 7'b0000011;
         C_SW:    return 7'b0100011;
         C_BEQ:   return 7'b1100011;
         C_JAL:   return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic logic [6:0] random_illegal_op();
      logic [6:0] o;
      for (int k = 0; k < 100; k++) begin
         o = 7'($urandom);
         if (o != 7'b0110011 && o != 7'b0010011 && o != 7'b0000011 &&
             o != 7'b0100011 && o != 7'b1100011 && o != 7'b1101111)
            return o;
      end
      return 7'b0000000;
   endfunction

   function automatic logic [1:0] imm_of(input logic [6:0] op);
      if (op == 7'b0100011) return 2'b01;
      if (op == 7'b1100011) return 2'b10;
      if (op == 7'b1101111) return 2'b11;
      return 2'b00;
   endfunction

   function automatic logic [2:0] alu_of(input logic is_r, input logic [2:0] f3, input logic f7b5);
      case (f3)
         3'b000:  return (is_r && f7b5) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   task automatic push(input ctl_t c, input logic rdy, input logic z, input logic ret);
      cyc_t e;
      e.c = c; e.rdy = rdy; e.zero = z; e.retire = ret;
      e.op = cur_op; e.f3 = cur_f3; e.f7 = cur_f7;
      exp_q.push_back(e);
   endtask

   // Expected cycle-by-cycle control words for one instruction, with wf
   // fetch wait cycles and wm data-memory wait cycles.
   task automatic build(input int cls, input logic [2:0] f3, input logic [6:0] f7,
                        input int wf, input int wm, input logic z);
      ctl_t b, c;
      cur_op = (cls == C_ILL) ? random_illegal_op() : op_of(cls);
      cur_f3 = f3;
      cur_f7 = f7;
      b = '0;
      b.imm = imm_of(cur_op);
      c = b; c.memreq = 1'b1; c.srcb = 2'b10; c.rsrc = 2'b10;
      repeat (wf) push(c, 1'b0, rb(), 1'b0);
      c.irwrite = 1'b1; c.pcupdate = 1'b1;
      push(c, 1'b1, rb(), 1'b0);
      c = b; c.srca = 2'b01; c.srcb = 2'b01; c.ill = (cls == C_ILL);
      push(c, rb(), rb(), 1'b0);
      case (cls)
         C_R, C_I: begin
            c = b; c.srca = 2'b10; c.srcb = (cls == C_I) ? 2'b01 : 2'b00;
            c.alu = alu_of(cls == C_R, f3, f7[5]);
            push(c, rb(), rb(), 1'b0);
            c = b; c.regwrite = 1'b1;
            push(c, rb(), rb(), 1'b1);
         end
         C_LW, C_SW: begin
            c = b; c.srca = 2'b10; c.srcb = 2'b01;
            push(c, rb(), rb(), 1'b0);
            c = b; c.memreq = 1'b1; c.adrsrc = 1'b1; c.memwrite = (cls == C_SW);
            repeat (wm) push(c, 1'b0, rb(), 1'b0);
            push(c, 1'b1, rb(), cls == C_SW);
            if (cls == C_LW) begin
               c = b; c.rsrc = 2'b01; c.regwrite = 1'b1;
               push(c, rb(), rb(), 1'b1);
            end
         end
         C_BEQ: begin
            c = b; c.srca = 2'b10; c.alu = 3'b001; c.pcupdate = z;
            push(c, rb(), z, 1'b1);
         end
         C_JAL: begin
            c = b; c.srca = 2'b01; c.srcb = 2'b10; c.pcupdate = 1'b1;
            push(c, rb(), rb(), 1'b0);
            c = b; c.regwrite = 1'b1;
            push(c, rb(), rb(), 1'b1);
         end
         default: ;
      endcase
   endtask

   task automatic test_reset();
      Op = 7'b0100011; MemReady = 1'b1; Zero = 1'b1;
      #2;
      vectors++;
      if (dut_ctl() !== ctl_t'('0) || InstRet !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_async: ctl=%h instret=%0d required ctl=0 instret=0", dut_ctl(), InstRet);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      vectors++;
      if (dut_ctl() !== ctl_t'('0) || InstRet !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_idle: ctl=%h instret=%0d required ctl=0 instret=0", dut_ctl(), InstRet);
      end
      @(posedge clk); #1;
      model_ret = '0;
   endtask

   task automatic test_directed();
      cyc_t e;
      int   n = 0;
      build(C_R,   3'b000, 7'b0000000, 0, 0, 1'b0);  // add
      build(C_R,   3'b000, 7'b0100000, 0, 0, 1'b0);  // sub
      build(C_I,   3'b000, 7'b0100000, 0, 0, 1'b0);  // addi, funct7[5] ignored
      build(C_LW,  3'b010, 7'b0000000, 0, 3, 1'b0);  // lw, 3 wait cycles
      build(C_BEQ, 3'b000, 7'b0000000, 0, 0, 1'b1);  // taken
      build(C_BEQ, 3'b000, 7'b0000000, 0, 0, 1'b0);  // not taken
      build(C_ILL, 3'b000, 7'b0000000, 0, 0, 1'b0);
      build(C_SW,  3'b010, 7'b0000000, 1, 2, 1'b0);
      build(C_JAL, 3'b000, 7'b0000000, 0, 0, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         Op = e.op; funct3 = e.f3; funct7 = e.f7; MemReady = e.rdy; Zero = e.zero;
         #1;
         vectors++;
         if (dut_ctl() !== e.c || InstRet !== exp_ret()) begin
            miscompares++;
            $display("FAIL directed cyc%0d op=%b: ctl=%h instret=%0d required ctl=%h instret=%0d",
                     n, e.op, dut_ctl(), InstRet, e.c, exp_ret());
         end
         @(posedge clk); #1;
         if (e.retire) model_ret++;
         n++;
      end
   endtask

   task automatic test_random();
      cyc_t e;
      int   n = 0;
      for (int i = 0; i < 200; i++) begin
         build($urandom_range(0, 6), 3'($urandom), 7'($urandom),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
               $urandom_range(0, 3), rb());
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            Op = e.op; funct3 = e.f3; funct7 = e.f7; MemReady = e.rdy; Zero = e.zero;
            #1;
            vectors++;
            if (dut_ctl() !== e.c || InstRet !== exp_ret()) begin
               miscompares++;
               $display("FAIL random cyc%0d op=%b f3=%b f7=%b: ctl=%h instret=%0d required ctl=%h instret=%0d",
                        n, e.op, e.f3, e.f7, dut_ctl(), InstRet, e.c, exp_ret());
            end
            @(posedge clk); #1;
            if (e.retire) model_ret++;
            n++;
         end
      end
   endtask

   task automatic test_reset_in_memwrite();
      cyc_t e;
      logic seen_wr = 1'b0;
      build(C_SW, 3'b010, 7'b0000000, 0, 3, 1'b0);
      while (exp_q.size() > 0 && !seen_wr) begin
         e = exp_q.pop_front();
         Op = e.op; funct3 = e.f3; funct7 = e.f7; MemReady = e.rdy; Zero = e.zero;
         #1;
         vectors++;
         if (dut_ctl() !== e.c || InstRet !== exp_ret()) begin
            miscompares++;
            $display("FAIL sw_pre_reset: ctl=%h instret=%0d required ctl=%h instret=%0d",
                     dut_ctl(), InstRet, e.c, exp_ret());
         end
         @(posedge clk); #1;
         if (e.retire) model_ret++;
         seen_wr = e.c.memwrite;
      end
      exp_q.delete();
      // second MEMWRITE wait cycle: strobe still held
      MemReady = 1'b0;
      #1;
      vectors++;
      if ({MemReq, MemWrite, AdrSrc} !== 3'b111) begin
         miscompares++;
         $display("FAIL sw_wait_hold: req/wr/adr=%b required 111", {MemReq, MemWrite, AdrSrc});
      end
      rst = 1'b1;
      #1;
      vectors++;
      if (dut_ctl() !== ctl_t'('0) || InstRet !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_mid_write: ctl=%h instret=%0d required ctl=0 instret=0", dut_ctl(), InstRet);
      end
      model_ret = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      MemReady = 1'b1;
      #1;
      vectors++;
      if (dut_ctl() !== ctl_t'('0) || InstRet !== 32'd0) begin
         miscompares++;
         $display("FAIL post_reset_idle: ctl=%h instret=%0d required ctl=0 instret=0", dut_ctl(), InstRet);
      end
      @(posedge clk); #1;
      build(C_R, 3'b111, 7'b0000000, 0, 0, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         Op = e.op; funct3 = e.f3; funct7 = e.f7; MemReady = e.rdy; Zero = e.zero;
         #1;
         vectors++;
         if (dut_ctl() !== e.c || InstRet !== exp_ret()) begin
            miscompares++;
            $display("FAIL post_reset_and: ctl=%h instret=%0d required ctl=%h instret=%0d",
                     dut_ctl(), InstRet, e.c, exp_ret());
         end
         @(posedge clk); #1;
         if (e.retire) model_ret++;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_reset_in_memwrite();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
